mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arb_wdt.sv | 26 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/exe memory arbiter: FSM states, access sizes, defaults.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned DEF_TIMEOUT    = 16;

    // Reserved size code is treated as an unserviceable access, like a misaligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// BUSY-cycle watchdog: expired is high during the TIMEOUT-th consecutive enabled cycle.
module mem_arb_wdt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, load/store) onto one memory port, with
// anti-starvation for fetch, alignment rejection and a BUSY timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_ack_o,
    output logic [31:0] fetch_data_o,
    output logic        fetch_err_o,
    input  logic        exe_req_i,
    input  logic        exe_we_i,
    input  logic [1:0]  exe_size_i,
    input  logic [31:0] exe_addr_i,
    input  logic [31:0] exe_wdata_i,
    output logic        exe_ack_o,
    output logic [31:0] exe_rdata_o,
    output logic        exe_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q;
    logic          winner_exe_q;
    logic          grant_exe, grant_fetch, reject;
    logic          expired, done;

    mem_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state_q != ST_BUSY),
        .enable  (state_q == ST_BUSY),
        .expired (expired)
    );

    // A coincident ack and expiry completes as a success.
    assign done = mem_ack_i || expired;

    always_comb begin
        state_d     = state_q;
        grant_exe   = 1'b0;
        grant_fetch = 1'b0;
        reject      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exe_req_i && !(fetch_req_i && streak_q == STREAK_MAX)) begin
                    grant_exe = 1'b1;
                end else if (fetch_req_i) begin
                    grant_fetch = 1'b1;
                end
                reject = grant_exe && misaligned(exe_size_i, exe_addr_i[1:0]);
                if (reject) begin
                    state_d = ST_RESP;
                end else if (grant_exe || grant_fetch) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: if (done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            streak_q     <= '0;
            winner_exe_q <= 1'b0;
            fetch_ack_o  <= 1'b0;
            fetch_err_o  <= 1'b0;
            fetch_data_o <= '0;
            exe_ack_o    <= 1'b0;
            exe_err_o    <= 1'b0;
            exe_rdata_o  <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_size_o   <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            state_q     <= state_d;
            fetch_ack_o <= 1'b0;
            fetch_err_o <= 1'b0;
            exe_ack_o   <= 1'b0;
            exe_err_o   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (reject) begin
                        exe_ack_o   <= 1'b1;
                        exe_err_o   <= 1'b1;
                        exe_rdata_o <= '0;
                    end else if (grant_exe) begin
                        winner_exe_q <= 1'b1;
                        mem_req_o    <= 1'b1;
                        mem_we_o     <= exe_we_i;
                        mem_size_o   <= exe_size_i;
                        mem_addr_o   <= exe_addr_i;
                        mem_wdata_o  <= exe_wdata_i;
                        if (!fetch_req_i) begin
                            streak_q <= '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (grant_fetch) begin
                        winner_exe_q <= 1'b0;
                        mem_req_o    <= 1'b1;
                        mem_we_o     <= 1'b0;
                        mem_size_o   <= SIZE_WORD;
                        mem_addr_o   <= fetch_addr_i;
                        mem_wdata_o  <= '0;
                        streak_q     <= '0;
                    end else begin
                        streak_q <= '0;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        mem_req_o <= 1'b0;
                        if (winner_exe_q) begin
                            exe_ack_o   <= 1'b1;
                            exe_err_o   <= !mem_ack_i;
                            exe_rdata_o <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                        end else begin
                            fetch_ack_o  <= 1'b1;
                            fetch_err_o  <= !mem_ack_i;
                            fetch_data_o <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ack, fetch_err;
    logic [31:0] fetch_data;
    logic        exe_req = 1'b0, exe_we = 1'b0;
    logic [1:0]  exe_size = 2'b10;
    logic [31:0] exe_addr = '0, exe_wdata = '0;
    logic        exe_ack, exe_err;
    logic [31:0] exe_rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fetch_req_i  (fetch_req),
        .fetch_addr_i (fetch_addr),
        .fetch_ack_o  (fetch_ack),
        .fetch_data_o (fetch_data),
        .fetch_err_o  (fetch_err),
        .exe_req_i    (exe_req),
        .exe_we_i     (exe_we),
        .exe_size_i   (exe_size),
        .exe_addr_i   (exe_addr),
        .exe_wdata_i  (exe_wdata),
        .exe_ack_o    (exe_ack),
        .exe_rdata_o  (exe_rdata),
        .exe_err_o    (exe_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_size_o   (mem_size),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_mem_req();
        int k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check1("mem_req_seen", mem_req, 1'b1);
    endtask

    logic [6:0] exp_fetch = 7'b001_0000;
    int         exe_cnt;
    int         busy_cnt;
    logic       saw_fetch, saw_exe;

    initial begin
        // Reset state
        repeat (3) tick();
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_fetch_ack", fetch_ack, 1'b0);
        check1("rst_exe_ack", exe_ack, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_fetch_data", fetch_data, 32'h0);
        rst = 1'b0;
        tick();

        // Stray mem_ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        tick();
        mem_ack = 1'b0;
        check1("stray_fetch_ack", fetch_ack, 1'b0);
        check1("stray_exe_ack", exe_ack, 1'b0);
        check1("stray_mem_req", mem_req, 1'b0);

        // Single fetch, ack two cycles after mem_req rises
        fetch_req = 1'b1; fetch_addr = 32'h100;
        tick();
        check1("f1_mem_req", mem_req, 1'b1);
        check32("f1_mem_addr", mem_addr, 32'h100);
        check1("f1_mem_we", mem_we, 1'b0);
        check32("f1_mem_size", 32'(mem_size), 32'd2);
        tick(); tick();
        check1("f1_mem_req_held", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check1("f1_fetch_ack", fetch_ack, 1'b1);
        check32("f1_fetch_data", fetch_data, 32'hDEAD_BEEF);
        check1("f1_fetch_err", fetch_err, 1'b0);
        check1("f1_exe_ack", exe_ack, 1'b0);
        check1("f1_mem_req_drop", mem_req, 1'b0);
        fetch_req = 1'b0;
        tick();
        check1("f1_ack_pulse", fetch_ack, 1'b0);

        // Simultaneous fetch and store: exe first, then fetch
        fetch_req = 1'b1; fetch_addr = 32'h104;
        exe_req = 1'b1; exe_we = 1'b1; exe_size = 2'b10;
        exe_addr = 32'h200; exe_wdata = 32'h1122_3344;
        tick();
        check1("sw_mem_req", mem_req, 1'b1);
        check1("sw_mem_we", mem_we, 1'b1);
        check32("sw_mem_addr", mem_addr, 32'h200);
        check32("sw_mem_wdata", mem_wdata, 32'h1122_3344);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check1("sw_exe_ack", exe_ack, 1'b1);
        check32("sw_exe_rdata", exe_rdata, 32'h0);
        check1("sw_fetch_ack", fetch_ack, 1'b0);
        exe_req = 1'b0; exe_we = 1'b0;
        tick();
        wait_mem_req();
        check32("f2_mem_addr", mem_addr, 32'h104);
        check1("f2_mem_we", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check1("f2_fetch_ack", fetch_ack, 1'b1);
        check32("f2_fetch_data", fetch_data, 32'h0BAD_F00D);
        fetch_req = 1'b0;
        tick();

        // Starvation limit: fetch held against 6 back-to-back loads
        fetch_req = 1'b1; fetch_addr = 32'h300;
        exe_req = 1'b1; exe_we = 1'b0; exe_size = 2'b10; exe_addr = 32'h400;
        exe_cnt = 0;
        for (int g = 0; g < 7; g++) begin
            wait_mem_req();
            check1($sformatf("grant%0d_is_fetch", g), mem_addr == 32'h300, exp_fetch[g]);
            mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(g);
            tick();
            mem_ack = 1'b0;
            saw_fetch = fetch_ack;
            saw_exe = exe_ack;
            check1($sformatf("grant%0d_fetch_ack", g), saw_fetch, exp_fetch[g]);
            check1($sformatf("grant%0d_exe_ack", g), saw_exe, !exp_fetch[g]);
            if (saw_fetch) fetch_req = 1'b0;
            if (saw_exe) begin
                check32($sformatf("grant%0d_exe_rdata", g), exe_rdata, 32'hA0 + 32'(g));
                exe_cnt++;
                if (exe_cnt == 6) exe_req = 1'b0;
            end
            tick();
        end
        check32("starve_exe_count", 32'(exe_cnt), 32'd6);

        // Rejected exe requests: word@0x202, reserved size, half@0x201
        for (int v = 0; v < 3; v++) begin
            exe_req = 1'b1; exe_we = 1'b0;
            exe_size = (v == 0) ? 2'b10 : (v == 1) ? 2'b11 : 2'b01;
            exe_addr = (v == 0) ? 32'h202 : (v == 1) ? 32'h200 : 32'h201;
            tick();
            check1($sformatf("rej%0d_exe_ack", v), exe_ack, 1'b1);
            check1($sformatf("rej%0d_exe_err", v), exe_err, 1'b1);
            check1($sformatf("rej%0d_mem_req", v), mem_req, 1'b0);
            check32($sformatf("rej%0d_rdata", v), exe_rdata, 32'h0);
            exe_req = 1'b0;
            tick();
            check1($sformatf("rej%0d_ack_pulse", v), exe_ack, 1'b0);
            check1($sformatf("rej%0d_mem_req_after", v), mem_req, 1'b0);
        end

        // Byte store at odd address is legal
        exe_req = 1'b1; exe_we = 1'b1; exe_size = 2'b00; exe_addr = 32'h203; exe_wdata = 32'h77;
        tick();
        check1("sb_mem_req", mem_req, 1'b1);
        check32("sb_mem_size", 32'(mem_size), 32'd0);
        check32("sb_mem_addr", mem_addr, 32'h203);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check1("sb_exe_ack", exe_ack, 1'b1);
        check1("sb_exe_err", exe_err, 1'b0);
        exe_req = 1'b0; exe_we = 1'b0;
        tick();

        // Timeout: no mem_ack ever
        fetch_req = 1'b1; fetch_addr = 32'h500;
        wait_mem_req();
        busy_cnt = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mem_req !== 1'b1) break;
            busy_cnt++;
        end
        check32("to_busy_cycles", 32'(busy_cnt), 32'd16);
        check1("to_fetch_ack", fetch_ack, 1'b1);
        check1("to_fetch_err", fetch_err, 1'b1);
        check32("to_fetch_data", fetch_data, 32'h0);
        fetch_req = 1'b0;
        tick();
        check1("to_err_clear", fetch_err, 1'b0);

        // Ack in the same cycle as expiry completes as success
        fetch_req = 1'b1; fetch_addr = 32'h600;
        wait_mem_req();
        repeat (15) tick();
        mem_ack = 1'b1; mem_rdata = 32'h600D_600D;
        tick();
        mem_ack = 1'b0;
        check1("edge_fetch_ack", fetch_ack, 1'b1);
        check1("edge_fetch_err", fetch_err, 1'b0);
        check32("edge_fetch_data", fetch_data, 32'h600D_600D);
        fetch_req = 1'b0;
        tick();

        // Reset one cycle into BUSY abandons the transaction
        exe_req = 1'b1; exe_we = 1'b1; exe_size = 2'b10; exe_addr = 32'h700; exe_wdata = 32'hCAFE;
        tick();
        check1("rb_mem_req_before", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("rb_mem_req", mem_req, 1'b0);
        check1("rb_exe_ack", exe_ack, 1'b0);
        check1("rb_fetch_ack", fetch_ack, 1'b0);
        check32("rb_mem_addr", mem_addr, 32'h0);
        wait_mem_req();
        check32("rb2_mem_addr", mem_addr, 32'h700);
        check32("rb2_mem_wdata", mem_wdata, 32'hCAFE);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check1("rb2_exe_ack", exe_ack, 1'b1);
        check1("rb2_exe_err", exe_err, 1'b0);
        exe_req = 1'b0; exe_we = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
